hyperbus_wb_master: RTL and testbench
=====================================

Name: hyperbus_wb_master

Overview:
Responder for the hbus request interface (adr/dat/mask/rrq/wrq in; dat/ready/valid/busy out). It turns each 16-bit hbus-style request into a single classic Wishbone master cycle on a 32-bit bus. Typical uses are loopback verification of the hbus FIFO path, and letting a HyperBus-side agent reach on-chip Wishbone slaves.

Parameters:
WB_ADDR_WIDTH, 32, Wishbone address width
WB_DATA_WIDTH, 32, Wishbone data width (only 32 supported)
HBUS_ADDR_WIDTH, 32, request address width (byte address)
HBUS_DATA_WIDTH, 16, request data width (only 16 supported)
MAX_RETRY, 4, wb_rty_i re-issues allowed before the request is failed
TIMEOUT, 256, ack watchdog in cycles (used only with HBUS_WB_TIMEOUT_EN)

Ports:
wb_clk  in  1  clock
wb_rst  in  1  synchronous active-high reset
hbus_adr_i  in  HBUS_ADDR_WIDTH  request byte address
hbus_dat_i  in  16  write data
hbus_mask_i  in  2  byte mask, 1 = byte NOT written
hbus_rrq  in  1  read request pulse
hbus_wrq  in  1  write request pulse
hbus_dat_o  out  16  read data
hbus_ready  out  1  write-complete pulse
hbus_valid  out  1  read-data-valid pulse
hbus_busy  out  1  request in progress
hbus_err  out  1  error pulse, coincident with ready/valid
wb_adr_o  out  WB_ADDR_WIDTH  word address
wb_dat_o  out  32  write data
wb_sel_o  out  4  byte selects
wb_we_o  out  1  write enable
wb_cyc_o  out  1  cycle
wb_stb_o  out  1  strobe
wb_cti_o  out  3  constant 3'b000
wb_bte_o  out  2  constant 2'b00
wb_dat_i  in  32  read data
wb_ack_i  in  1  ack
wb_err_i  in  1  error
wb_rty_i  in  1  retry

Behaviour:
- Reset values: all outputs 0. State IDLE. Retry counter 0.
- States: IDLE, CYCLE, RETRY, RESP.
- IDLE accepts a request only while hbus_busy=0.
  - wrq and rrq in the same cycle: the write is taken and rrq is dropped.
  - On accept, latch adr, dat, mask and direction. busy=1 from the next cycle.
- Address mapping: wb_adr_o={adr[WB_ADDR_WIDTH-1:2],2'b00}. lane=adr[1]. adr[0] is ignored.
- Write:
  - wb_dat_o={dat,dat}.
  - wb_sel_o={~mask,2'b00} if lane=1, else {2'b00,~mask}.
  - mask=2'b11: no Wishbone cycle. Go straight to RESP; ready pulses 2 cycles after the request; err=0.
- Read: wb_sel_o=1100 if lane=1, else 0011. Mask is ignored.
- CYCLE: cyc=stb=1, we per direction. Outputs are held stable until termination.
- Termination, first of ack/err/rty (priority ack > err > rty):
  - ack: go to RESP. For a read, dat_o is captured from wb_dat_i[31:16] if lane=1, else wb_dat_i[15:0].
  - err: go to RESP with err flagged. Read dat_o=16'h0000.
  - rty: go to RETRY, where cyc=stb=0 for exactly one cycle, then back to CYCLE.
  - On the (MAX_RETRY+1)-th rty: go to RESP with err flagged.
- Termination always drops cyc/stb on the following edge; there is no back-to-back stb.
- RESP (1 cycle):
  - Pulse ready (write) or valid (read), plus err if flagged.
  - busy=0 in this cycle, so a new request can be accepted here.
  - Return to IDLE. Retry counter cleared.
- Latency: request at cycle 0; cyc/stb at cycle 1; ack sampled at cycle k; ready/valid at k+1.
  - Zero-wait slave (ack in cycle 1): ready/valid at cycle 2. Back-to-back throughput is one request per 2 cycles.
- hbus_dat_o holds its last value until the next read completes.
- Requests arriving while busy=1 are ignored; there is no queuing.
- wb_rst mid-cycle: cyc/stb/busy low after the reset edge. The pending request is discarded, and no ready/valid/err is emitted.

Optional Feature:
HBUS_WB_TIMEOUT_EN:
- Defined: a counter starts when entering CYCLE and clears on RETRY/RESP.
  - If TIMEOUT cycles pass with no ack/err/rty, drop cyc/stb and go to RESP with err flagged. Read data is 0.
  - An ack arriving in the same cycle the count expires wins; no err.
- Undefined: no counter; CYCLE waits indefinitely.

Test Plan:
1. wrq, adr=0x1002, dat=0xBEEF, mask=00, slave acks in 1 cycle -> wb_adr_o=0x1000, wb_dat_o=0xBEEFBEEF, sel=1100, we=1; ready at cycle 2; busy high cycles 1-1, low at 2.
2. Memory word 0x12345678 at 0x20: rrq adr=0x20 -> sel=0011, valid with dat_o=0x5678. rrq adr=0x22 -> valid with dat_o=0x1234.
3. wrq mask=01 lane 0 -> sel=0010. wrq mask=11 -> no cyc asserted; ready at cycle 2.
4. Slave returns rty 2x then ack (MAX_RETRY=4) -> stb low 1 cycle between attempts, 3 strobes total, ready with err=0. Slave rty 5x -> err=1 with ready after the 5th rty.
5. wrq+rrq in the same cycle -> one write cycle only, no valid. wb_rst asserted during CYCLE -> cyc=0 next edge, no ready/valid.
6. With HBUS_WB_TIMEOUT_EN, TIMEOUT=8, slave never acks -> cyc drops after 8 cycles; valid=1, err=1, dat_o=0.

Source files
------------

// File: rtl/hyperbus_wb_master.sv
// hbus 16-bit request responder: each request becomes one classic 32-bit Wishbone master cycle.
// Latency: request at cycle 0, cyc/stb at cycle 1, ready/valid one cycle after ack/err/final rty.
// Backpressure: hbus_busy masks new requests; optional ack watchdog under `HBUS_WB_TIMEOUT_EN.
module hyperbus_wb_master #(
    parameter int WB_ADDR_WIDTH   = 32,
    parameter int WB_DATA_WIDTH   = 32,
    parameter int HBUS_ADDR_WIDTH = 32,
    parameter int HBUS_DATA_WIDTH = 16,
    parameter int MAX_RETRY       = 4,
    parameter int TIMEOUT         = 256
) (
    input  logic                       wb_clk,
    input  logic                       wb_rst,
    input  logic [HBUS_ADDR_WIDTH-1:0] hbus_adr_i,
    input  logic [HBUS_DATA_WIDTH-1:0] hbus_dat_i,
    input  logic [1:0]                 hbus_mask_i,
    input  logic                       hbus_rrq,
    input  logic                       hbus_wrq,
    output logic [HBUS_DATA_WIDTH-1:0] hbus_dat_o,
    output logic                       hbus_ready,
    output logic                       hbus_valid,
    output logic                       hbus_busy,
    output logic                       hbus_err,
    output logic [WB_ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [WB_DATA_WIDTH-1:0]   wb_dat_o,
    output logic [3:0]                 wb_sel_o,
    output logic                       wb_we_o,
    output logic                       wb_cyc_o,
    output logic                       wb_stb_o,
    output logic [2:0]                 wb_cti_o,
    output logic [1:0]                 wb_bte_o,
    input  logic [WB_DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                       wb_ack_i,
    input  logic                       wb_err_i,
    input  logic                       wb_rty_i
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CYCLE = 2'd1;
    localparam logic [1:0] ST_RETRY = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;
    localparam int RW = $clog2(MAX_RETRY + 2);

    logic [1:0]                 r_state;
    logic [WB_ADDR_WIDTH-3:0]   r_wadr;
    logic                       r_lane;
    logic [HBUS_DATA_WIDTH-1:0] r_dat;
    logic [1:0]                 r_mask;
    logic                       r_we;
    logic                       r_null;
    logic                       r_err;
    logic [RW-1:0]              r_rty_cnt;
    logic [HBUS_DATA_WIDTH-1:0] r_dat_o;

    logic       w_accept;
    logic       w_cyc;
    logic       w_timeout;
    logic       w_fail;
    logic [3:0] w_sel;
    logic       w_unused;

    assign hbus_busy = (r_state == ST_CYCLE) || (r_state == ST_RETRY);
    assign w_accept  = (hbus_wrq || hbus_rrq) && !hbus_busy;
    // A fully masked write sits one cycle in CYCLE with no strobe so ready keeps the usual 2-cycle latency.
    assign w_cyc     = (r_state == ST_CYCLE) && !r_null;
    assign w_fail    = wb_err_i || (wb_rty_i && (r_rty_cnt == RW'(MAX_RETRY))) || w_timeout;

`ifdef HBUS_WB_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT + 1);
    logic [TOW-1:0] r_to_cnt;

    always_ff @(posedge wb_clk) begin
        if (wb_rst || (r_state != ST_CYCLE)) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == ST_CYCLE) && (r_to_cnt == TOW'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_state   <= ST_IDLE;
            r_wadr    <= '0;
            r_lane    <= 1'b0;
            r_dat     <= '0;
            r_mask    <= '0;
            r_we      <= 1'b0;
            r_null    <= 1'b0;
            r_err     <= 1'b0;
            r_rty_cnt <= '0;
            r_dat_o   <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_RESP: begin
                    r_rty_cnt <= '0;
                    if (w_accept) begin
                        r_wadr  <= hbus_adr_i[WB_ADDR_WIDTH-1:2];
                        r_lane  <= hbus_adr_i[1];
                        r_dat   <= hbus_dat_i;
                        r_mask  <= hbus_mask_i;
                        r_we    <= hbus_wrq;
                        r_null  <= hbus_wrq && (hbus_mask_i == 2'b11);
                        r_err   <= 1'b0;
                        r_state <= ST_CYCLE;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CYCLE: begin
                    if (r_null) begin
                        r_state <= ST_RESP;
                    end else if (wb_ack_i) begin
                        r_state <= ST_RESP;
                        if (!r_we) begin
                            r_dat_o <= r_lane ? wb_dat_i[31:16] : wb_dat_i[15:0];
                        end
                    end else if (w_fail) begin
                        r_state <= ST_RESP;
                        r_err   <= 1'b1;
                        if (!r_we) begin
                            r_dat_o <= '0;
                        end
                    end else if (wb_rty_i) begin
                        r_rty_cnt <= r_rty_cnt + 1'b1;
                        r_state   <= ST_RETRY;
                    end
                end
                ST_RETRY: r_state <= ST_CYCLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_sel = 4'b0000;
        if (r_we) begin
            w_sel = r_lane ? {~r_mask, 2'b00} : {2'b00, ~r_mask};
        end else begin
            w_sel = r_lane ? 4'b1100 : 4'b0011;
        end
    end

    assign wb_cyc_o = w_cyc;
    assign wb_stb_o = w_cyc;
    assign wb_we_o  = w_cyc && r_we;
    assign wb_adr_o = w_cyc ? {r_wadr, 2'b00} : '0;
    assign wb_dat_o = (w_cyc && r_we) ? {r_dat, r_dat} : '0;
    assign wb_sel_o = w_cyc ? w_sel : 4'b0000;
    assign wb_cti_o = 3'b000;
    assign wb_bte_o = 2'b00;

    assign hbus_ready = (r_state == ST_RESP) && r_we;
    assign hbus_valid = (r_state == ST_RESP) && !r_we;
    assign hbus_err   = (r_state == ST_RESP) && r_err;
    assign hbus_dat_o = r_dat_o;

    // Byte-address bit 0 has no meaning on a 16-bit request.
    assign w_unused = ^{hbus_adr_i[0], (TIMEOUT > 0)};

endmodule

// File: tb/tb_hyperbus_wb_master.sv
// Randomized bench for hyperbus_wb_master: byte-level reference memory plus per-request timing model.
module tb_hyperbus_wb_master;
    localparam int MAXR = 4;
    localparam int TMO  = 8;

    logic        wb_clk = 1'b0;
    logic        wb_rst;
    logic [31:0] hbus_adr_i;
    logic [15:0] hbus_dat_i;
    logic [1:0]  hbus_mask_i;
    logic        hbus_rrq, hbus_wrq;
    logic [15:0] hbus_dat_o;
    logic        hbus_ready, hbus_valid, hbus_busy, hbus_err;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic        wb_ack_i, wb_err_i, wb_rty_i;

    always #5 wb_clk = ~wb_clk;

    hyperbus_wb_master #(.MAX_RETRY(MAXR), .TIMEOUT(TMO)) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst),
        .hbus_adr_i(hbus_adr_i), .hbus_dat_i(hbus_dat_i), .hbus_mask_i(hbus_mask_i),
        .hbus_rrq(hbus_rrq), .hbus_wrq(hbus_wrq),
        .hbus_dat_o(hbus_dat_o), .hbus_ready(hbus_ready), .hbus_valid(hbus_valid),
        .hbus_busy(hbus_busy), .hbus_err(hbus_err),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] smem [0:15];   // slave-side word memory
    logic [7:0]  rmem [0:63];   // reference byte memory
    logic [15:0] exp_dat_o = 16'h0000;

    int          o_resp, o_strobes;
    logic [31:0] o_adr, o_dat;
    logic [3:0]  o_sel;
    logic        o_we;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic txn(input bit is_wr, input bit both, input logic [31:0] adr, input logic [15:0] dat,
                       input logic [1:0] mask, input int nrty, input bit fin_err, input int wst);
        bit          wr, nul, e_err, done;
        int          att, e_resp, wcnt, base;
        logic [3:0]  e_sel;
        logic [31:0] e_adr;
        wr    = is_wr || both;
        nul   = wr && (mask == 2'b11);
        e_adr = {adr[31:2], 2'b00};
        base  = int'({adr[5:1], 1'b0});
        if (nul) begin
            att = 0; e_err = 1'b0; e_resp = 2;
        end else begin
            if (nrty > MAXR) begin att = MAXR + 1; e_err = 1'b1; end
            else begin att = nrty + 1; e_err = fin_err; end
            e_resp = att * (wst + 2);
        end
        if (wr) e_sel = adr[1] ? {~mask, 2'b00} : {2'b00, ~mask};
        else    e_sel = adr[1] ? 4'b1100 : 4'b0011;
        if (!wr) exp_dat_o = e_err ? 16'h0000 : {rmem[base+1], rmem[base]};
        if (wr && !e_err) begin
            for (int b = 0; b < 2; b++) if (!mask[b]) rmem[base+b] = dat[8*b +: 8];
        end

        o_resp = -1; o_strobes = 0; o_adr = '0; o_dat = '0; o_sel = '0; o_we = 1'b0;
        hbus_adr_i = adr; hbus_dat_i = dat; hbus_mask_i = mask;
        hbus_wrq = wr; hbus_rrq = !is_wr || both;
        @(negedge wb_clk);
        done = 1'b0; wcnt = 0;
        for (int c = 1; c <= 200 && !done; c++) begin
            hbus_wrq = 1'b0; hbus_rrq = 1'b0;
            if (c < e_resp) begin
                chk("busy_hi", 32'(hbus_busy), 32'd1);
                chk("no_pulse", {29'd0, hbus_ready, hbus_valid, hbus_err}, 32'd0);
            end else begin
                o_resp = c;
                chk("busy_lo", 32'(hbus_busy), 32'd0);
                chk("ready", 32'(hbus_ready), 32'(wr));
                chk("valid", 32'(hbus_valid), 32'(!wr));
                chk("err", 32'(hbus_err), 32'(e_err));
                chk("dat_o", 32'(hbus_dat_o), 32'(exp_dat_o));
                done = 1'b1;
            end
            if (wb_cyc_o) begin
                if (wb_ack_i === 1'b0 && wb_rty_i === 1'b0 && wb_err_i === 1'b0 && wcnt == 0) begin
                    o_strobes++;
                end
                chk("wb_adr", wb_adr_o, e_adr);
                chk("wb_sel", 32'(wb_sel_o), 32'(e_sel));
                chk("wb_we", 32'(wb_we_o), 32'(wr));
                chk("wb_stb", {27'd0, wb_stb_o, wb_cti_o, wb_bte_o}, {27'd0, 1'b1, 3'b000, 2'b00});
                if (wr) chk("wb_dat", wb_dat_o, {dat, dat});
                o_adr = wb_adr_o; o_dat = wb_dat_o; o_sel = wb_sel_o; o_we = wb_we_o;
            end
            wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_dat_i = $urandom;
            if (wb_cyc_o) begin
                if (wcnt == wst) begin
                    wcnt = 0;
                    if (o_strobes <= nrty) wb_rty_i = 1'b1;
                    else if (fin_err) wb_err_i = 1'b1;
                    else begin
                        wb_ack_i = 1'b1;
                        if (wb_we_o) begin
                            for (int b = 0; b < 4; b++)
                                if (wb_sel_o[b]) smem[wb_adr_o[5:2]][8*b +: 8] = wb_dat_o[8*b +: 8];
                        end else wb_dat_i = smem[wb_adr_o[5:2]];
                    end
                end else wcnt++;
            end
            // Stray requests while busy must be ignored.
            if (!done && ($urandom_range(0, 3) == 0)) begin
                hbus_adr_i = $urandom; hbus_dat_i = $urandom; hbus_mask_i = $urandom;
                hbus_wrq = $urandom; hbus_rrq = $urandom;
            end
            if (!done) @(negedge wb_clk);
        end
        chk("resp_cycle", o_resp, e_resp);
        chk("strobes", o_strobes, att);
    endtask

    initial begin
        int cyc_n;
        for (int i = 0; i < 16; i++) smem[i] = 32'h0;
        for (int i = 0; i < 64; i++) rmem[i] = 8'h0;
        wb_rst = 1'b1; hbus_adr_i = '0; hbus_dat_i = '0; hbus_mask_i = '0;
        hbus_rrq = 1'b0; hbus_wrq = 1'b0;
        wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
        repeat (2) @(negedge wb_clk);
        chk("rst_hbus", {11'd0, hbus_dat_o, hbus_ready, hbus_valid, hbus_busy, hbus_err, 1'b0}, 32'd0);
        chk("rst_wb_ctl", {21'd0, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o}, 32'd0);
        chk("rst_wb_adr", wb_adr_o | wb_dat_o, 32'd0);
        wb_rst = 1'b0;

        txn(1, 0, 32'h1002, 16'hBEEF, 2'b00, 0, 0, 0);
        chk("t1_adr", o_adr, 32'h0000_1000);
        chk("t1_dat", o_dat, 32'hBEEF_BEEF);
        chk("t1_sel", 32'(o_sel), 32'h0000_000C);
        chk("t1_lat", o_resp, 2);

        txn(1, 0, 32'h20, 16'h5678, 2'b00, 0, 0, 0);
        txn(1, 0, 32'h22, 16'h1234, 2'b00, 0, 0, 1);
        txn(0, 0, 32'h20, 16'h0000, 2'b10, 0, 0, 0);
        chk("t2_lo", 32'(hbus_dat_o), 32'h0000_5678);
        chk("t2_sel", 32'(o_sel), 32'h0000_0003);
        txn(0, 0, 32'h22, 16'h0000, 2'b00, 0, 0, 2);
        chk("t2_hi", 32'(hbus_dat_o), 32'h0000_1234);

        txn(1, 0, 32'h30, 16'hA5C3, 2'b01, 0, 0, 0);
        chk("t3_sel", 32'(o_sel), 32'h0000_0002);
        txn(1, 0, 32'h34, 16'h7777, 2'b11, 0, 0, 0);
        chk("t3_null_stb", o_strobes, 0);
        chk("t3_null_lat", o_resp, 2);

        txn(1, 0, 32'h08, 16'h4321, 2'b00, 2, 0, 0);
        chk("t4_rty_stb", o_strobes, 3);
        chk("t4_rty_err", 32'(hbus_err), 32'd0);
        chk("t4_rty_lat", o_resp, 6);
        txn(0, 0, 32'h08, 16'h0000, 2'b00, 5, 0, 0);
        chk("t4_exh_stb", o_strobes, 5);
        chk("t4_exh_err", 32'(hbus_err), 32'd1);
        chk("t4_exh_lat", o_resp, 10);

        txn(0, 1, 32'h12, 16'h9ABC, 2'b00, 0, 0, 0);
        chk("t5_both_we", 32'(o_we), 32'd1);
        chk("t5_both_stb", o_strobes, 1);

        // Reset while a read cycle is stalled: no response may follow.
        hbus_adr_i = 32'h40; hbus_rrq = 1'b1;
        @(negedge wb_clk);
        hbus_rrq = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("rst_mid_cyc", 32'(wb_cyc_o), 32'd1);
            @(negedge wb_clk);
        end
        wb_rst = 1'b1;
        @(negedge wb_clk);
        wb_rst = 1'b0;
        chk("rst_mid_drop", {29'd0, wb_cyc_o, wb_stb_o, hbus_busy}, 32'd0);
        for (int c = 0; c < 4; c++) begin
            chk("rst_mid_quiet", {29'd0, hbus_ready, hbus_valid, hbus_err}, 32'd0);
            @(negedge wb_clk);
        end
        exp_dat_o = 16'h0000;

`ifdef HBUS_WB_TIMEOUT_EN
        cyc_n = 0;
        hbus_adr_i = 32'h24; hbus_rrq = 1'b1;
        @(negedge wb_clk);
        hbus_rrq = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (wb_cyc_o) cyc_n++;
            if (c == TMO + 1) begin
                chk("to_valid", {29'd0, hbus_valid, hbus_err, hbus_ready}, 32'd6);
                chk("to_dat", 32'(hbus_dat_o), 32'd0);
            end
            @(negedge wb_clk);
        end
        chk("to_cycles", cyc_n, TMO);
`else
        cyc_n = 0;
`endif

        for (int t = 0; t < 150; t++) begin
            bit          w, bth, fe;
            int          nr;
            logic [31:0] a;
            w   = $urandom_range(0, 1);
            bth = ($urandom_range(0, 9) == 0);
            fe  = ($urandom_range(0, 7) == 0);
            nr  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : 0;
            a   = {$urandom_range(0, 255), 18'd0, 6'($urandom_range(0, 63))};
            txn(w, bth, a, 16'($urandom), 2'($urandom), nr, fe, $urandom_range(0, 2));
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 2)) @(negedge wb_clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
